// File: rtl/dmem_responder_if.sv
// Data-memory bus between the core (master) and the memory/MMIO responder (slave).
// Loads are combinational, so ReadData is valid in the same cycle as the address.
interface dmem_responder_if;
  logic [31:0] Addr;
  logic        MemWrite;
  logic [31:0] WriteData;
  logic [2:0]  Funct3;
  logic [31:0] ReadData;

  modport master (
    output Addr, MemWrite, WriteData, Funct3,
    input  ReadData
  );

  modport slave (
    input  Addr, MemWrite, WriteData, Funct3,
    output ReadData
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-cycle data-memory responder: word RAM with byte/half lanes plus a 16-byte MMIO page
// holding a free-running counter, a timer compare, sticky W1C status flags and an LED register.
module dmem_responder #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] MMIO_BASE = 32'h0000_1000
) (
  input  logic                    clk,
  input  logic                    Reset,
  dmem_responder_if.slave         bus,
  output logic [7:0]              LED,
  output logic                    timer_irq
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] RAM_END  = 32'(DEPTH * 4);
  localparam logic [31:0] MMIO_END = MMIO_BASE + 32'd16;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    REG_CNT    = 2'd0,
    REG_CMP    = 2'd1,
    REG_STATUS = 2'd2,
    REG_LED    = 2'd3
  } mmio_reg_e;

  logic [31:0] mem [DEPTH];

  logic [31:0] cnt;
  logic [31:0] cmp;
  logic        hit;
  logic        mis;
  logic        err;
  logic [7:0]  led_q;

  logic          in_ram;
  logic          in_mmio;
  logic          in_hole;
  logic          is_b;
  logic          is_h;
  logic          is_w;
  logic          is_unsigned;
  logic          f3_legal;
  logic          aligned;
  logic          mis_evt;
  logic          err_evt;
  logic          hit_evt;
  logic          access_ok;
  logic          wr_ok;
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram_word;
  mmio_reg_e     mmio_reg;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wdata;
  logic          ram_we;
  logic [2:0]    status_clr;

  // Address and width decode shared by the load and store paths.
  always_comb begin
    in_ram   = bus.Addr < RAM_END;
    in_mmio  = (bus.Addr >= MMIO_BASE) && (bus.Addr < MMIO_END);
    in_hole  = !in_ram && !in_mmio;
    ram_idx  = bus.Addr[AW+1:2];
    mmio_reg = mmio_reg_e'(bus.Addr[3:2]);

    is_b        = 1'b0;
    is_h        = 1'b0;
    is_w        = 1'b0;
    is_unsigned = 1'b0;
    f3_legal    = 1'b1;
    case (funct3_e'(bus.Funct3))
      F3_B:    is_b = 1'b1;
      F3_H:    is_h = 1'b1;
      F3_W:    is_w = 1'b1;
      F3_BU:   begin is_b = 1'b1; is_unsigned = 1'b1; end
      F3_HU:   begin is_h = 1'b1; is_unsigned = 1'b1; end
      default: f3_legal = 1'b0;
    endcase

    aligned = is_w ? (bus.Addr[1:0] == 2'b00) :
              is_h ? !bus.Addr[0] : 1'b1;

    // The MMIO page only accepts aligned word accesses; anything narrower counts as misaligned.
    mis_evt   = !f3_legal
              || (in_ram  && !aligned)
              || (in_mmio && !(is_w && bus.Addr[1:0] == 2'b00));
    err_evt   = in_hole;
    access_ok = !mis_evt && !err_evt;
    wr_ok     = bus.MemWrite && access_ok && !Reset;
    hit_evt   = (cmp != 32'd0) && (cnt == cmp);
  end

  // Load path: pure combinational mux, so a read during a write sees the pre-edge contents.
  always_comb begin
    ram_word = mem[ram_idx];

    case (bus.Addr[1:0])
      2'd0:    rd_byte = ram_word[7:0];
      2'd1:    rd_byte = ram_word[15:8];
      2'd2:    rd_byte = ram_word[23:16];
      default: rd_byte = ram_word[31:24];
    endcase
    rd_half = bus.Addr[1] ? ram_word[31:16] : ram_word[15:0];

    bus.ReadData = 32'd0;
    if (access_ok && in_ram) begin
      if (is_b)
        bus.ReadData = is_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      else if (is_h)
        bus.ReadData = is_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
      else
        bus.ReadData = ram_word;
    end else if (access_ok && in_mmio) begin
      case (mmio_reg)
        REG_CNT:    bus.ReadData = cnt;
        REG_CMP:    bus.ReadData = cmp;
        REG_STATUS: bus.ReadData = {29'd0, err, mis, hit};
        default:    bus.ReadData = {24'd0, led_q};
      endcase
    end
  end

  // Store lane steering: narrow stores are replicated across lanes and masked by byte enables.
  always_comb begin
    ram_be    = 4'b0000;
    ram_wdata = bus.WriteData;
    if (is_b) begin
      ram_be    = 4'b0001 << bus.Addr[1:0];
      ram_wdata = {4{bus.WriteData[7:0]}};
    end else if (is_h) begin
      ram_be    = bus.Addr[1] ? 4'b1100 : 4'b0011;
      ram_wdata = {2{bus.WriteData[15:0]}};
    end else if (is_w) begin
      ram_be    = 4'b1111;
    end
    ram_we = wr_ok && in_ram;

    status_clr = 3'b000;
    if (wr_ok && in_mmio && mmio_reg == REG_STATUS)
      status_clr = bus.WriteData[2:0];
  end

  // NOTE: the RAM array has no reset branch so it maps onto plain memory; contents survive Reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i])
          mem[ram_idx][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt   <= 32'd0;
      cmp   <= 32'd0;
      hit   <= 1'b0;
      mis   <= 1'b0;
      err   <= 1'b0;
      led_q <= 8'd0;
    end else begin
      cnt <= cnt + 32'd1;
      if (wr_ok && in_mmio && mmio_reg == REG_CMP)
        cmp <= bus.WriteData;
      if (wr_ok && in_mmio && mmio_reg == REG_LED)
        led_q <= bus.WriteData[7:0];
      // A set event in the same cycle as a W1C clear leaves the flag set.
      hit <= (hit && !status_clr[0]) || hit_evt;
      mis <= (mis && !status_clr[1]) || mis_evt;
      err <= (err && !status_clr[2]) || err_evt;
    end
  end

  assign LED       = led_q;
  assign timer_irq = hit;

endmodule
